// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through byte FIFO and serialises each
// byte as an asynchronous UART frame (start, 8 data LSB first, optional parity,
// 1 or 2 stop bits). Consecutive frames are sent with no idle gap.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  output logic        txd,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic            PAR_POL   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par_bit, par_nx;
  logic          txd_nx;
  logic          frame_inc;
  logic          bit_end;
  logic          last_stop_cycle;
  logic          pop;

  // Parity of a byte with the configured sense folded in.
  function automatic logic parity_of(input logic [7:0] d);
    return (^d) ^ PAR_POL;
  endfunction

  // Pop decision: a new byte may be taken from idle or on the final stop cycle.
  always_comb begin
    bit_end         = (clk_cnt == CLK_LAST);
    last_stop_cycle = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
    pop             = tx_en && !fifo_empty && ((state == IDLE) || last_stop_cycle);
    fifo_rd         = pop && rst;
    busy            = (state != IDLE);
  end

  // Next-state, counters, shift register and next line level.
  always_comb begin
    state_nx   = state;
    clk_cnt_nx = bit_end ? '0 : clk_cnt + CW'(1);
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    par_nx     = par_bit;
    frame_inc  = 1'b0;
    txd_nx     = 1'b1;

    case (state)
      IDLE: begin
        clk_cnt_nx = '0;
      end
      START: begin
        if (bit_end) begin
          state_nx   = DATA;
          bit_cnt_nx = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_nx = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_nx   = (PARITY_EN != 0) ? PARITY : STOP;
            bit_cnt_nx = 3'd0;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nx   = STOP;
          bit_cnt_nx = 3'd0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            state_nx   = IDLE;
            bit_cnt_nx = 3'd0;
            frame_inc  = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_nx   = IDLE;
        clk_cnt_nx = '0;
        bit_cnt_nx = 3'd0;
      end
    endcase

    // A pop only occurs from IDLE or the last stop cycle, so it overrides both.
    if (pop) begin
      state_nx   = START;
      shreg_nx   = fifo_data;
      par_nx     = parity_of(fifo_data);
      bit_cnt_nx = 3'd0;
      clk_cnt_nx = '0;
    end

    // The line is registered, so it is driven from the level of the next state.
    case (state_nx)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = shreg_nx[0];
      PARITY:  txd_nx = par_nx;
      default: txd_nx = 1'b1;
    endcase
  end

  // Control state, line register and frame counter; cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= 3'd0;
      txd       <= 1'b1;
      frame_cnt <= 16'd0;
    end else begin
      state   <= state_nx;
      clk_cnt <= clk_cnt_nx;
      bit_cnt <= bit_cnt_nx;
      txd     <= txd_nx;
      if (frame_inc) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Data holding registers; only meaningful after a pop loads them.
  always_ff @(posedge clk) begin
    shreg   <= shreg_nx;
    par_bit <= par_nx;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the 8-bit, 16-deep byte FIFO and sends each byte as an asynchronous UART frame on `txd`. It sits directly downstream of the FIFO. It pops one byte when the FIFO is non-empty and the transmitter is idle or finishing a frame, then serialises the byte. Frames go back-to-back with no idle gap while data is available.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be ≥ 2. Counter width is `$clog2(CLKS_PER_BIT)`.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: parity sense when `PARITY_EN` = 1 (0 = even, 1 = odd).
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_en`  in  1  permits popping new bytes. It never aborts a frame already in progress.
- `fifo_data`  in  8  FIFO read data (first-word fall-through). It is valid whenever `fifo_empty` = 0.
- `fifo_empty`  in  1  FIFO empty flag, registered in the FIFO.
- `fifo_rd`  out  1  pop strobe to the FIFO, combinational, one cycle per byte.
- `txd`  out  1  serial line, registered, idles high.
- `busy`  out  1  1 whenever state ≠ IDLE.
- `frame_cnt`  out  16  count of completed frames, wraps 0xFFFF → 0x0000.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition, `pop = tx_en & ~fifo_empty & (state == IDLE | last_stop_cycle)`. `fifo_rd = pop`, forced to 0 while `rst` = 0.
- On a pop edge:
  - `shreg <= fifo_data`.
  - Parity register <= `^fifo_data ^ PARITY_ODD`.
  - `bit_cnt <= 0`, `clk_cnt <= 0`.
  - state <= START.
- START: `txd` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: 8 bits sent LSB first.
  - `txd` = `shreg[0]`; `shreg` shifts right at the end of each bit.
  - `bit_cnt` counts 0..7.
  - After bit 7: go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `txd` = parity register for one bit time, then go to STOP.
- STOP: `txd` = 1 for `STOP_BITS*CLKS_PER_BIT` cycles.
  - `last_stop_cycle` = final cycle of STOP.
  - On that edge `frame_cnt` increments.
  - Next state is START if `pop`, else IDLE.
- `tx_en` dropping mid-frame: the current frame completes, no further pop occurs, and the block enters IDLE.
- The FIFO's registered empty flag is always settled before the next pop, because a frame lasts ≥ 20 cycles.

## Timing
- Reset values: `txd` = 1, `busy` = 0, `fifo_rd` = 0, `frame_cnt` = 0, state = IDLE, all counters 0.
- Reset mid-frame:
  - `txd` returns to 1 asynchronously.
  - The byte in flight is discarded and not re-popped.
  - `frame_cnt` is not incremented.
- Latency: for a pop at edge T, `txd` falls (start bit) and `busy` rises after edge T. So the first start-bit cycle is cycle T+1.
- Frame length `F = (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT` cycles.
- Back-to-back frames: the next start bit begins exactly F cycles after the previous one, with zero idle cycles.
- `txd` is glitch-free because it is driven from a flop.
- `fifo_rd` is high for exactly one cycle per frame and never high while `fifo_empty` = 1.
- `frame_cnt` updates on the same edge that leaves the final stop cycle.

## Test plan
- Basic frame (`CLKS_PER_BIT`=4, no parity, 1 stop):
  - Stimulus: FIFO holds 0x55, `tx_en`=1.
  - Required: one `fifo_rd` pulse; `txd` = 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; 40 cycles total; then `busy`=0 and `frame_cnt`=1.
- Back-to-back:
  - Stimulus: FIFO holds 0xA5, 0x3C.
  - Required: second start bit begins exactly 40 cycles after the first; data bits of the second frame are 0,0,1,1,1,1,0,0; `fifo_rd` pulses are 40 cycles apart; `frame_cnt`=2.
- Parity:
  - Stimulus: `PARITY_EN`=1, byte 0x07.
  - Required: parity bit = 1 with `PARITY_ODD`=0 and 0 with `PARITY_ODD`=1; frame = 44 cycles.
  - Stimulus: `STOP_BITS`=2.
  - Required: `txd` stays high for 8 stop cycles.
- Flow control:
  - Stimulus: 3 bytes queued; `tx_en` dropped during frame 1's DATA state.
  - Required: frame 1 completes, no second pop, block goes IDLE with `txd`=1.
  - Stimulus: `tx_en` raised again.
  - Required: frames 2 and 3 are sent.
- Reset mid-frame:
  - Stimulus: assert `rst` during DATA bit 3 of 0xF0.
  - Required: `txd`=1 immediately; `busy`=0; `frame_cnt`=0.
  - Stimulus: release reset with the FIFO empty.
  - Required: `fifo_rd` stays 0.
- Counter wrap:
  - Stimulus: preload/force `frame_cnt`=0xFFFF, then send one byte.
  - Required: `frame_cnt`=0x0000 after the final stop cycle.
